sni_uart: RTL



---
 rtl/sni_pkg.sv | 26 ++
 rtl/sni_uart_if.sv | 12 +
 rtl/sni_uart_rx.sv | 106 ++++++++++
 rtl/sni_uart.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sni_pkg.sv
// rtl/sni_pkg.sv - shared types and constants for the SNI serial transceiver
package sni_pkg;

    localparam int SNI_CLKS_PER_BIT_DEFAULT = 746;

    // tdata_m / rdata_m bit positions
    localparam int SEND_EN = 8;
    localparam int FERR    = 8;
    localparam int OVR     = 9;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/sni_uart_if.sv
// rtl/sni_uart_if.sv - engine-side byte handshake between the SNI command engine and the UART
interface sni_uart_if;
    logic        rbf;
    logic        rxint;
    logic [15:0] rdata_m;
    logic        tdata_i;
    logic [15:0] tdata_m;
    logic        txint;

    modport master (output rbf, tdata_i, tdata_m, input rxint, rdata_m, txint);
    modport slave  (input rbf, tdata_i, tdata_m, output rxint, rdata_m, txint);
endinterface

// File: rtl/sni_uart_rx.sv
// rtl/sni_uart_rx.sv - UART receiver: pin synchroniser, mid-bit sampler, one-cycle done strobe
module sni_uart_rx
    import sni_pkg::*;
#(
    parameter int CLKS_PER_BIT = SNI_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_ferr,
    output logic       rx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, sync3_q;
    rx_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            ferr_q, ferr_d;
    logic            done_q, done_d;
    logic            fall;

    // sync3 only serves edge detection; sampling uses sync2
    assign fall = sync3_q & ~sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    ferr_d  = ~sync2_q;
                    done_d  = 1'b1;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
        end
    end

    assign rx_byte = shreg_q;
    assign rx_ferr = ferr_q;
    assign rx_done = done_q;

endmodule

// File: rtl/sni_uart.sv
// rtl/sni_uart.sv - SNI UART top: TX serialiser, rxint stretcher, overrun and RTS/CTS flow control
// Optional build macro: SNI_UART_FLOWCTL_EN enables RTS from rbf and CTS-gated transmit start.
module sni_uart
    import sni_pkg::*;
#(
    parameter int CLKS_PER_BIT = SNI_CLKS_PER_BIT_DEFAULT,
    parameter int RXINT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic       uart_cts_n,
    output logic       uart_rts_n,
    sni_uart_if.slave  eng
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int RI_W  = $clog2(RXINT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic [7:0] rx_byte;
    logic       rx_ferr;
    logic       rx_done;

    sni_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rxd     (uart_rxd),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr),
        .rx_done (rx_done)
    );

    logic            rxint_q, rxint_d;
    logic [RI_W-1:0] ricnt_q, ricnt_d;
    logic [8:0]      rdata_q, rdata_d;
    logic            ovr_q, ovr_d;
    logic            rts_q, rts_d;
    tx_state_t       tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic            txd_q, txd_d;
    logic            txint_q, txint_d;
    logic            tx_go;
    logic            unused_inputs;

    assign unused_inputs = ^{eng.tdata_m[15:9], uart_cts_n};

`ifdef SNI_UART_FLOWCTL_EN
    logic cts1_q, cts2_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts1_q <= 1'b1;
            cts2_q <= 1'b1;
        end else begin
            cts1_q <= uart_cts_n;
            cts2_q <= cts1_q;
        end
    end
    assign tx_go = ~cts2_q;
    assign rts_d = eng.rbf;
`else
    assign tx_go = 1'b1;
    assign rts_d = 1'b0;
`endif

    // Delivery and overrun: a full engine buffer drops the byte and latches the sticky flag
    always_comb begin
        rxint_d = rxint_q;
        ricnt_d = ricnt_q;
        rdata_d = rdata_q;
        ovr_d   = ovr_q;
        if (rxint_q) begin
            if (ricnt_q == '0) rxint_d = 1'b0;
            else               ricnt_d = ricnt_q - 1'b1;
        end
        if (rx_done) begin
            if (eng.rbf) begin
                ovr_d = 1'b1;
            end else begin
                rdata_d = {rx_ferr, rx_byte};
                rxint_d = 1'b1;
                ricnt_d = RI_W'(RXINT_CYCLES - 1);
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        txint_d    = txint_q;
        case (tx_state_q)
            TX_IDLE: begin
                // txint high in idle only happens for a no-send strobe: drop after one cycle
                if (txint_q) begin
                    txint_d = 1'b0;
                end else if (eng.tdata_i) begin
                    txint_d = 1'b1;
                    tx_sh_d = eng.tdata_m[7:0];
                    if (eng.tdata_m[SEND_EN]) tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_go) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_sh_q[0];
                    tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_FULL) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                    txint_d    = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxint_q    <= 1'b0;
            ricnt_q    <= '0;
            rdata_q    <= '0;
            ovr_q      <= 1'b0;
            rts_q      <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            txint_q    <= 1'b0;
        end else begin
            rxint_q    <= rxint_d;
            ricnt_q    <= ricnt_d;
            rdata_q    <= rdata_d;
            ovr_q      <= ovr_d;
            rts_q      <= rts_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            txint_q    <= txint_d;
        end
    end

    assign uart_txd    = txd_q;
    assign uart_rts_n  = rts_q;
    assign eng.rxint   = rxint_q;
    assign eng.rdata_m = {6'b0, ovr_q, rdata_q};
    assign eng.txint   = txint_q;

endmodule
